// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: state encoding,
// opcode fields and the register-number constant that never forms a hazard.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MUL        = 2'd2
  } hz_state_e;

  localparam logic [4:0] OPC_LDI    = 5'b01100;
  localparam logic [3:0] REG_NONE   = 4'hF;
  localparam int         OPCODE_MSB = 15;
  localparam int         OPCODE_LSB = 11;

endpackage

// File: rtl/hazard_mul_timer.sv
// Loadable down-counter that times the multiply freeze. A load wins over a
// decrement; the count never wraps below zero.
module hazard_mul_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stall, taken-branch squash and
// multi-cycle multiply freeze. Outputs are combinational from state and
// inputs and are forced low while rst is high.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters with a synchronous clear.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_id_ex,
  input  logic        RegWrite_id_ex,
  input  logic [3:0]  write_address_id_ex,
  input  logic [15:0] instruction_if_id,
  input  logic [3:0]  read_address1_if_id,
  input  logic [3:0]  read_address2_if_id,
  input  logic        branch_taken_ex,
  input  logic        mul_start_ex,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  // Timer holds the number of S_MUL cycles still to run after the entry cycle.
  localparam int CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_LATENCY > 2) ? (MUL_LATENCY - 2) : 0);

  hz_state_e   state_d, state_q;
  logic        tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0] tmr_value;
  logic [4:0]  opcode;
  logic        load_use;
  logic        unused_instr_bits;

  assign opcode            = instruction_if_id[OPCODE_MSB:OPCODE_LSB];
  assign unused_instr_bits = ^instruction_if_id[OPCODE_LSB-1:0];

  // A load in EX feeding a register read in ID; r15 and LDI never depend.
  assign load_use = mem_read_id_ex && RegWrite_id_ex &&
                    (write_address_id_ex != REG_NONE) &&
                    (opcode != OPC_LDI) &&
                    ((write_address_id_ex == read_address1_if_id) ||
                     (write_address_id_ex == read_address2_if_id));

  hazard_mul_timer #(.W(CW)) u_mul_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (MUL_LOAD),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Next-state and pipeline control decode.
  always_comb begin
    state_d       = state_q;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    busy          = 1'b0;
    case (state_q)
      S_RUN: begin
        if (branch_taken_ex) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (mul_start_ex && (MUL_LATENCY > 1)) begin
          // Entry cycle is the first freeze cycle; latency 2 needs no S_MUL.
          ex_mem_bubble = 1'b1;
          busy          = 1'b1;
          tmr_load      = 1'b1;
          state_d       = (MUL_LOAD == '0) ? S_RUN : S_MUL;
        end else if (load_use) begin
          id_ex_write = 1'b1;
          id_ex_flush = 1'b1;
          busy        = 1'b1;
          state_d     = S_LOAD_STALL;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_write = 1'b1;
        end
      end
      S_LOAD_STALL: begin
        // Load has moved to MEM, forwarding covers it: resume unconditionally.
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        state_d     = S_RUN;
      end
      S_MUL: begin
        ex_mem_bubble = 1'b1;
        busy          = 1'b1;
        tmr_dec       = 1'b1;
        if (tmr_zero || (tmr_value == CW'(1)))
          state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      busy          = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;
  logic [CNT_W-1:0] flush_count_d, flush_count_q;

  // Saturating event counters; clear overrides counting.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if (busy && !(&stall_cycles_q))
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (if_id_flush && !(&flush_count_q))
        flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed vector table, reset-abort
// sequence, randomized run against a countdown reference model, and the
// optional performance counters when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_control_unit;

  // Output vector order: {pc_write, if_id_write, id_ex_write,
  //                       if_id_flush, id_ex_flush, ex_mem_bubble, busy}
  localparam logic [6:0] E_RUN = 7'b1110000;
  localparam logic [6:0] E_LU  = 7'b0010101;
  localparam logic [6:0] E_BR  = 7'b1111100;
  localparam logic [6:0] E_MUL = 7'b0000011;
  localparam logic [6:0] E_RST = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr, rw, br, mul;
  logic [3:0]  wa, ra1, ra2;
  logic [15:0] instr;
  logic        pc3, ifw3, idw3, iff3, idf3, bub3, busy3;
  logic        pc1, ifw1, idw1, iff1, idf1, bub1, busy1;
  logic [6:0]  o3, o1;
  int          errors = 0;
  int          checks = 0;
  int          rem [2];
  bit          stl [2];

`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr;
  logic [15:0] stall3, flush3;
  logic [1:0]  stall1, flush1;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.MUL_LATENCY(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .mem_read_id_ex(mr), .RegWrite_id_ex(rw),
    .write_address_id_ex(wa), .instruction_if_id(instr),
    .read_address1_if_id(ra1), .read_address2_if_id(ra2),
    .branch_taken_ex(br), .mul_start_ex(mul),
    .pc_write(pc3), .if_id_write(ifw3), .id_ex_write(idw3),
    .if_id_flush(iff3), .id_ex_flush(idf3), .ex_mem_bubble(bub3), .busy(busy3)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_clr(perf_clr), .stall_cycles(stall3), .flush_count(flush3)
`endif
  );

  hazard_control_unit #(.MUL_LATENCY(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read_id_ex(mr), .RegWrite_id_ex(rw),
    .write_address_id_ex(wa), .instruction_if_id(instr),
    .read_address1_if_id(ra1), .read_address2_if_id(ra2),
    .branch_taken_ex(br), .mul_start_ex(mul),
    .pc_write(pc1), .if_id_write(ifw1), .id_ex_write(idw1),
    .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_bubble(bub1), .busy(busy1)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_clr(perf_clr), .stall_cycles(stall1), .flush_count(flush1)
`endif
  );

  assign o3 = {pc3, ifw3, idw3, iff3, idf3, bub3, busy3};
  assign o1 = {pc1, ifw1, idw1, iff1, idf1, bub1, busy1};

  typedef struct {
    logic        mr, rw;
    logic [3:0]  wa;
    logic [15:0] instr;
    logic [3:0]  ra1, ra2;
    logic        br, mul;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic m, input logic r, input logic [3:0] w,
                              input logic [15:0] ins, input logic [3:0] a1,
                              input logic [3:0] a2, input logic b, input logic mu,
                              input logic [6:0] e);
    vec_t v;
    v.mr = m; v.rw = r; v.wa = w; v.instr = ins; v.ra1 = a1; v.ra2 = a2;
    v.br = b; v.mul = mu; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    mr = 0; rw = 0; wa = 0; instr = 16'h0; ra1 = 0; ra2 = 0; br = 0; mul = 0;
  endtask

  // Reference: rem counts freeze cycles still owed, stl marks the resume
  // cycle following a load-use stall.
  task automatic model(input int k, input int lat, output logic [6:0] e);
    bit lu;
    lu = mr && rw && (wa != 4'd15) && (instr[15:11] != 5'b01100) &&
         (wa == ra1 || wa == ra2);
    if (rem[k] > 0) begin
      e = E_MUL; rem[k] = rem[k] - 1;
    end else if (stl[k]) begin
      e = E_RUN; stl[k] = 0;
    end else if (br) begin
      e = E_BR;
    end else if (mul && lat > 1) begin
      e = E_MUL; rem[k] = lat - 2;
    end else if (lu) begin
      e = E_LU; stl[k] = 1;
    end else begin
      e = E_RUN;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    check("reset_l3", o3, E_RST);
    check("reset_l1", o1, E_RST);
    @(posedge clk); #1;
    rst = 0;
    rem[0] = 0; rem[1] = 0; stl[0] = 0; stl[1] = 0;
  endtask

  initial begin
    logic [6:0] e3, e1;
    int r;
    rst = 1;
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 0;
`endif
    // Directed table, applied back to back from reset.
    tbl[0]  = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 0, E_RUN);
    tbl[1]  = mk(1, 1, 4'd3,  16'h0000, 4'd5,  4'd3, 0, 0, E_LU);
    tbl[2]  = mk(1, 1, 4'd3,  16'h0000, 4'd5,  4'd3, 0, 0, E_RUN);
    tbl[3]  = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 0, E_RUN);
    tbl[4]  = mk(1, 1, 4'd15, 16'h0000, 4'd15, 4'd1, 0, 0, E_RUN);
    tbl[5]  = mk(1, 1, 4'd3,  16'h6000, 4'd3,  4'd0, 0, 0, E_RUN);
    tbl[6]  = mk(1, 1, 4'd3,  16'h0000, 4'd3,  4'd0, 1, 0, E_BR);
    tbl[7]  = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 0, E_RUN);
    tbl[8]  = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 1, E_MUL);
    tbl[9]  = mk(1, 1, 4'd2,  16'h0000, 4'd2,  4'd0, 1, 1, E_MUL);
    tbl[10] = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 0, E_RUN);
    tbl[11] = mk(1, 0, 4'd4,  16'h0000, 4'd4,  4'd0, 0, 0, E_RUN);
    tbl[12] = mk(1, 1, 4'd7,  16'h1234, 4'd7,  4'd0, 0, 0, E_LU);
    tbl[13] = mk(0, 0, 4'd0,  16'h0000, 4'd0,  4'd0, 0, 1, E_RUN);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      mr = tbl[i].mr; rw = tbl[i].rw; wa = tbl[i].wa; instr = tbl[i].instr;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2; br = tbl[i].br; mul = tbl[i].mul;
      @(negedge clk);
      check($sformatf("vec%0d", i), o3, tbl[i].exp);
      @(posedge clk); #1;
    end

    // Latency 1: a multiply start alone never freezes.
    idle(); mul = 1;
    @(negedge clk);
    check("l1_mul_nofreeze", o1, E_RUN);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("l1_after_mul", o1, E_RUN);
    check("l3_mul_entry_second", o3, E_MUL);
    // Reset lands in the second freeze cycle.
    #1 rst = 1;
    #1 check("rst_mid_mul", o3, E_RST);
    @(posedge clk); #1;
    check("rst_held", o3, E_RST);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst_run", o3, E_RUN);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_no_bubble", o3, E_RUN);
    @(posedge clk); #1;

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 4);  wa  = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4);  ra1 = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4);  ra2 = (r == 4) ? 4'd15 : 4'(r);
      mr = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 2);
      instr = 16'($urandom);
      if (r == 0) instr[15:11] = 5'b01100;
      br  = ($urandom_range(0, 7) == 0);
      mul = ($urandom_range(0, 7) == 0);
      model(0, 3, e3);
      model(1, 1, e1);
      @(negedge clk);
      check($sformatf("rand%0d_l3", n), o3, e3);
      check($sformatf("rand%0d_l1", n), o1, e1);
      @(posedge clk); #1;
    end

`ifdef HAZARD_PERF_CNT_EN
    // One load stall, one multiply, one branch.
    do_reset();
    mr = 1; rw = 1; wa = 4'd3; ra2 = 4'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle(); mul = 1;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    br = 1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("perf_stall_l3", stall3, 16'd3);
    check("perf_flush_l3", flush3, 16'd1);
    check("perf_stall_l1", stall1, 2'd1);
    check("perf_flush_l1", flush1, 2'd1);
    perf_clr = 1; br = 1;
    @(posedge clk); #1;
    perf_clr = 0; br = 0;
    @(negedge clk);
    check("perf_clr_stall", stall3, 16'd0);
    check("perf_clr_flush", flush3, 16'd0);
    // Saturation on the 2-bit counters of the latency-1 instance.
    br = 1;
    repeat (5) begin @(posedge clk); #1; end
    br = 0; mr = 1; rw = 1; wa = 4'd6; ra1 = 4'd6;
    repeat (10) begin @(posedge clk); #1; end
    idle();
    @(negedge clk);
    check("perf_sat_flush", flush1, 2'd3);
    check("perf_sat_stall", stall1, 2'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage, 16-bit-instruction, 16-register core.
- Sits beside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve:
  - load-use stalls, detected in ID;
  - taken-branch squash, resolved in EX;
  - multi-cycle multiply freeze in EX.
- Drives the write-enables and flushes of the PC, IF/ID and ID/EX registers, plus the bubble into EX/MEM.

Parameters:
- MUL_LATENCY, 3, total EX cycles of a multiply (>=1); the block inserts MUL_LATENCY-1 freeze cycles.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- mem_read_id_ex  in  1  instruction in EX is a load
- RegWrite_id_ex  in  1  instruction in EX writes a register
- write_address_id_ex  in  4  destination register of the instruction in EX
- instruction_if_id  in  16  instruction in ID
- read_address1_if_id  in  4  source register 1 of the instruction in ID
- read_address2_if_id  in  4  source register 2 of the instruction in ID
- branch_taken_ex  in  1  branch in EX resolved as taken
- mul_start_ex  in  1  multiply entered EX this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- id_ex_write  out  1  ID/EX load enable
- if_id_flush  out  1  zero the IF/ID register
- id_ex_flush  out  1  zero the ID/EX control fields (bubble)
- ex_mem_bubble  out  1  zero the EX/MEM control fields
- busy  out  1  a stall or freeze is in progress

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- While rst=1:
  - state=S_RUN, counter=0;
  - pc_write, if_id_write and id_ex_write are 0;
  - all flushes, ex_mem_bubble and busy are 0.
- After reset, outputs are combinational from state and inputs; state and counter are registered.
- States: S_RUN, S_LOAD_STALL, S_MUL.
- load_use = mem_read_id_ex & RegWrite_id_ex & (write_address_id_ex!=4'hF) & opcode!=OPC_LDI & (write_address_id_ex==read_address1_if_id | write_address_id_ex==read_address2_if_id).
  - opcode = instruction_if_id[15:11].
- S_RUN, priority order:
  1. branch_taken_ex: if_id_flush=1, id_ex_flush=1, pc_write=1. The pending load_use and mul_start_ex are ignored. Next state S_RUN.
  2. mul_start_ex with MUL_LATENCY>1: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, busy=1. Counter loads MUL_LATENCY-2. Next state S_MUL.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1, busy=1. Next state S_LOAD_STALL.
  4. Otherwise all write-enables are 1.
- S_LOAD_STALL: lasts exactly one cycle.
  - All write-enables are 1; load_use detection is masked, because the load is now in MEM and forwarding covers it.
  - branch_taken_ex is impossible here, since EX holds a bubble.
  - Next state S_RUN.
- S_MUL:
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, busy=1.
  - Counter decrements each cycle; when it reaches 0, next state is S_RUN.
  - mul_start_ex, branch_taken_ex and load_use are ignored.
- Freeze length: exactly MUL_LATENCY-1 consecutive ex_mem_bubble cycles, counting the entry cycle.
- MUL_LATENCY=1: mul_start_ex has no effect.
- Reset mid-S_MUL or mid-S_LOAD_STALL aborts immediately to S_RUN with no residual stall.
- Register 15 is never a hazard source.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds the following ports.
  - perf_clr (in, 1): synchronous clear, takes precedence over increments.
  - stall_cycles (out, CNT_W): counts cycles with busy=1.
  - flush_count (out, CNT_W): counts cycles with if_id_flush=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding typedef;
  - OPC_LDI=5'b01100;
  - REG_NONE=4'hF;
  - OPCODE_MSB=15 and OPCODE_LSB=11.
- One sub-module, hazard_mul_timer: loadable down-counter with load/value/zero outputs, instantiated once.

Test Plan:
- Load-use: EX holds a load to r3, ID reads r3 on read_address2 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, then normal operation; the next cycle does not re-trigger.
- Register-15 and LDI exemptions:
  - a load to r15 with ID reading r15 → no stall;
  - opcode 01100 in ID reading r3 behind a load to r3 → no stall.
- Branch priority: branch_taken_ex=1 together with load_use=1 → if_id_flush=1, id_ex_flush=1, pc_write=1, no stall state entered.
- Multiply: MUL_LATENCY=3, mul_start_ex pulse → exactly 2 cycles of ex_mem_bubble=1 with all write-enables 0, then S_RUN. With MUL_LATENCY=1 → no freeze.
- Reset during the second S_MUL cycle → all enables and flushes 0 while rst is high; after release, normal operation with no leftover bubble.
- With HAZARD_PERF_CNT_EN: 1 load stall + 2-cycle multiply + 1 branch → stall_cycles=3, flush_count=1; perf_clr → both 0; forcing stall_cycles to all-ones → it holds there.
